// File: rtl/bus_memtest_pkg.sv
// Shared types and constants for the bus memory self-test initiator.
package bus_memtest_pkg;

    localparam int         BUS_AW  = 32;
    localparam int         BUS_DW  = 32;
    localparam logic [3:0] BE_FULL = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_WAIT,
        DONE
    } state_e;

    // Byte address of word idx; the 32-bit add wraps by design.
    function automatic logic [BUS_AW-1:0] word_addr(input logic [BUS_AW-1:0] base,
                                                    input logic [BUS_AW-1:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/bus_memtest.sv
// Memory self-test bus initiator: writes seed^index to 2**WORDS_POW words,
// reads them back, and reports error count, first failing address and timeout.
module bus_memtest
    import bus_memtest_pkg::*;
#(
    parameter int WORDS_POW    = 10,
    parameter int RESP_TIMEOUT = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [BUS_AW-1:0]     base_addr_bi,
    input  logic [BUS_DW-1:0]     seed_bi,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [WORDS_POW:0]    err_cnt_o,
    output logic [BUS_AW-1:0]     first_err_addr_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [BUS_AW-1:0]     bus_addr_bo,
    output logic [3:0]            bus_be_bo,
    output logic [BUS_DW-1:0]     bus_wdata_bo,
    input  logic                  bus_ack_i,
    input  logic                  bus_resp_i,
    input  logic [BUS_DW-1:0]     bus_rdata_bi
);

    localparam int                  CW       = $clog2(RESP_TIMEOUT + 1);
    localparam logic [WORDS_POW-1:0] LAST_IDX = '1;
    localparam logic [CW-1:0]        TMO_LAST = CW'(RESP_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [WORDS_POW-1:0]   idx_q, idx_d;
    logic [BUS_AW-1:0]      base_q, base_d;
    logic [BUS_DW-1:0]      seed_q, seed_d;
    logic [CW-1:0]          tmo_q, tmo_d;
    logic [WORDS_POW:0]     err_cnt_q, err_cnt_d;
    logic [BUS_AW-1:0]      first_err_q, first_err_d;
    logic                   pass_q, pass_d;
    logic                   timeout_q, timeout_d;

    logic [BUS_AW-1:0]      cur_addr;
    logic [BUS_DW-1:0]      cur_pattern;

    assign cur_addr    = word_addr(base_q, BUS_AW'(idx_q));
    assign cur_pattern = seed_q ^ BUS_DW'(idx_q);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        base_d      = base_q;
        seed_d      = seed_q;
        tmo_d       = tmo_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = WR_REQ;
                    idx_d       = '0;
                    base_d      = base_addr_bi & ~BUS_AW'(3);
                    seed_d      = seed_bi;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            WR_REQ: begin
                if (bus_ack_i) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = RD_REQ;
                    end else begin
                        idx_d = idx_q + WORDS_POW'(1);
                    end
                end
            end
            RD_REQ: begin
                if (bus_ack_i) begin
                    state_d = RD_WAIT;
                    tmo_d   = '0;
                end
            end
            RD_WAIT: begin
                if (bus_resp_i) begin
                    if (bus_rdata_bi != cur_pattern) begin
                        err_cnt_d = err_cnt_q + (WORDS_POW+1)'(1);
                        if (err_cnt_q == '0) first_err_d = cur_addr;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + WORDS_POW'(1);
                        state_d = RD_REQ;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    if (err_cnt_q == '0) first_err_d = cur_addr;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Verdict is latched on entry to DONE so it is valid alongside done_o.
        if (state_d == DONE && state_q != DONE) begin
            pass_d = (err_cnt_d == '0) && !timeout_d;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            base_q      <= '0;
            seed_q      <= '0;
            tmo_q       <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            seed_q      <= seed_d;
            tmo_q       <= tmo_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

    // All outputs decode flops only; address and data are stable while a request stalls.
    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == DONE);
    assign pass_o           = pass_q;
    assign timeout_o        = timeout_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;
    assign bus_req_o        = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign bus_we_o         = (state_q == WR_REQ);
    assign bus_addr_bo      = cur_addr;
    assign bus_be_bo        = BE_FULL;
    assign bus_wdata_bo     = cur_pattern;

endmodule

// File: tb/tb_bus_memtest.sv
// Self-checking bench for bus_memtest: a behavioural RAM responder with
// configurable ack stall, read latency and corruption, plus result prediction.
module tb_bus_memtest;

    localparam int WP = 2;
    localparam int N  = 4;
    localparam int T  = 16;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] base_addr_bi;
    logic [31:0] seed_bi;
    logic        busy_o, done_o, pass_o, timeout_o;
    logic [WP:0] err_cnt_o;
    logic [31:0] first_err_addr_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_bo;
    logic [3:0]  bus_be_bo;
    logic [31:0] bus_wdata_bo;
    logic        bus_ack_i, bus_resp_i;
    logic [31:0] bus_rdata_bi;

    bus_memtest #(.WORDS_POW(WP), .RESP_TIMEOUT(T)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .base_addr_bi(base_addr_bi), .seed_bi(seed_bi),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_bo(bus_addr_bo),
        .bus_be_bo(bus_be_bo), .bus_wdata_bo(bus_wdata_bo),
        .bus_ack_i(bus_ack_i), .bus_resp_i(bus_resp_i), .bus_rdata_bi(bus_rdata_bi)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Responder model state
    bit [31:0] mem     [bit [31:0]];
    bit [31:0] corrupt [bit [31:0]];
    bit [31:0] wr_addr_q[$];
    bit [31:0] wr_data_q[$];
    int        ack_dly, rd_lat, stall, resp_cnt, first_rd_ack;
    bit        no_resp, resp_pend, prev_stall;
    bit [31:0] resp_addr, prev_addr, prev_wdata;
    bit        prev_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; afterwards DUT outputs reflect the new cycle and the
    // responder has driven ack/resp for it.
    task automatic tick();
        bit [31:0] d;
        @(posedge clk);
        #1;
        cyc++;
        bus_resp_i   = 1'b0;
        bus_rdata_bi = $urandom;
        if (resp_pend) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                d = mem.exists(resp_addr) ? mem[resp_addr] : 32'hDEAD_BEEF;
                if (corrupt.exists(resp_addr)) d = d ^ corrupt[resp_addr];
                bus_resp_i   = 1'b1;
                bus_rdata_bi = d;
                resp_pend    = 1'b0;
            end
        end
        bus_ack_i = 1'b0;
        if (bus_req_o) begin
            if (prev_stall) begin
                check("hold_addr",  bus_addr_bo,  prev_addr);
                check("hold_we",    32'(bus_we_o), 32'(prev_we));
                if (bus_we_o) check("hold_wdata", bus_wdata_bo, prev_wdata);
            end
            if (stall == ack_dly) begin
                bus_ack_i  = 1'b1;
                stall      = 0;
                prev_stall = 1'b0;
                check("be", 32'(bus_be_bo), 32'hF);
                if (bus_we_o) begin
                    mem[bus_addr_bo] = bus_wdata_bo;
                    wr_addr_q.push_back(bus_addr_bo);
                    wr_data_q.push_back(bus_wdata_bo);
                end else begin
                    if (first_rd_ack < 0) first_rd_ack = cyc;
                    if (!no_resp) begin
                        resp_pend = 1'b1;
                        resp_cnt  = rd_lat;
                        resp_addr = bus_addr_bo;
                    end
                end
            end else begin
                stall++;
                prev_stall = 1'b1;
                prev_addr  = bus_addr_bo;
                prev_we    = bus_we_o;
                prev_wdata = bus_wdata_bo;
            end
        end else begin
            prev_stall = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"},    32'(busy_o), 0);
        check({pfx, "_done"},    32'(done_o), 0);
        check({pfx, "_pass"},    32'(pass_o), 0);
        check({pfx, "_timeout"}, 32'(timeout_o), 0);
        check({pfx, "_errcnt"},  32'(err_cnt_o), 0);
        check({pfx, "_firsterr"}, first_err_addr_o, 0);
        check({pfx, "_req"},     32'(bus_req_o), 0);
        check({pfx, "_we"},      32'(bus_we_o), 0);
        check({pfx, "_addr"},    bus_addr_bo, 0);
        check({pfx, "_wdata"},   bus_wdata_bo, 0);
    endtask

    task automatic responder_setup(input int d, input int l, input bit nr,
                                   input logic [31:0] base, input logic [3:0][31:0] masks);
        bit [31:0] b;
        ack_dly = d; rd_lat = l; no_resp = nr;
        stall = 0; resp_pend = 0; prev_stall = 0; first_rd_ack = -1;
        mem.delete(); corrupt.delete();
        wr_addr_q.delete(); wr_data_q.delete();
        b = base & ~32'h3;
        for (int i = 0; i < N; i++) corrupt[b + 32'(4*i)] = masks[i];
    endtask

    task automatic run(input string name, input logic [31:0] base, input logic [31:0] seed,
                       input int d, input int l, input bit nr,
                       input logic [3:0][31:0] masks, input bit stray);
        int        c0, exp_done, exp_err;
        bit        seen;
        bit [31:0] b, exp_first;
        responder_setup(d, l, nr, base, masks);
        b = base & ~32'h3;
        base_addr_bi = base;
        seed_bi      = seed;
        start_i      = 1'b1;
        c0 = cyc;
        tick();
        start_i      = 1'b0;
        base_addr_bi = $urandom;
        seed_bi      = $urandom;
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (done_o) begin seen = 1'b1; break; end
            start_i = stray && busy_o && ($urandom_range(0, 5) == 0);
            tick();
        end
        start_i = 1'b0;
        check({name, "_done_seen"}, 32'(seen), 1);

        exp_err   = 0;
        exp_first = 0;
        if (nr) begin
            exp_done  = N*(d+1) + (d+1) + T + 1;
            exp_first = b;
        end else begin
            exp_done = N*(d+1) + N*(d+1+l) + 1;
            for (int i = 0; i < N; i++) begin
                if (masks[i] != 0) begin
                    if (exp_err == 0) exp_first = b + 32'(4*i);
                    exp_err++;
                end
            end
        end
        check({name, "_done_cycle"}, 32'(cyc - c0), 32'(exp_done));
        check({name, "_pass"},    32'(pass_o), 32'((exp_err == 0) && !nr));
        check({name, "_timeout"}, 32'(timeout_o), 32'(nr));
        check({name, "_errcnt"},  32'(err_cnt_o), 32'(exp_err));
        check({name, "_firsterr"}, first_err_addr_o, exp_first);
        if (nr) check({name, "_rd_ack_to_done"}, 32'(cyc - first_rd_ack), 32'(T + 1));

        check({name, "_nwrites"}, 32'(wr_addr_q.size()), 32'(N));
        for (int i = 0; i < N && i < wr_addr_q.size(); i++) begin
            check({name, "_wr_addr"}, wr_addr_q[i], b + 32'(4*i));
            check({name, "_wr_data"}, wr_data_q[i], seed ^ 32'(i));
        end

        tick();
        check({name, "_busy_after"}, 32'(busy_o), 0);
        check({name, "_done_pulse"}, 32'(done_o), 0);
        check({name, "_pass_held"},  32'(pass_o), 32'((exp_err == 0) && !nr));
        check({name, "_tmo_held"},   32'(timeout_o), 32'(nr));
    endtask

    initial begin
        logic [3:0][31:0] m;
        bit               aborted;

        rst_i = 1'b1; start_i = 1'b0; base_addr_bi = '0; seed_bi = '0;
        bus_ack_i = 1'b0; bus_resp_i = 1'b0; bus_rdata_bi = '0;
        ack_dly = 0; rd_lat = 1; no_resp = 0; stall = 0; resp_pend = 0;
        prev_stall = 0; first_rd_ack = -1;
        tick(); tick();
        check_all_zero("reset");
        rst_i = 1'b0;
        tick();

        m = '0;
        run("ideal", 32'h8000_0000, 32'hA5A5_0000, 0, 2, 0, m, 0);

        m = '0; m[2] = 32'h0000_0001; m[3] = 32'h0100_0000;
        run("corrupt", 32'h8000_0000, 32'hA5A5_0000, 0, 2, 0, m, 0);

        m = '0;
        run("stall", 32'h8000_0000, 32'hA5A5_0000, 3, 2, 0, m, 0);
        run("timeout", 32'h8000_0000, 32'hA5A5_0000, 0, 2, 1, m, 0);
        run("wrap", 32'hFFFF_FFF8, 32'h1234_5678, 0, 1, 0, m, 0);
        run("stray_start", 32'h0000_1003, 32'hCAFE_F00D, 1, 3, 0, m, 1);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++)
                m[i] = ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            run("rand", $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 4),
                ($urandom_range(0, 9) == 0), m, $urandom_range(0, 1));
        end

        // Reset while waiting for a read response.
        m = '0;
        responder_setup(0, 3, 0, 32'h4000_0000, m);
        base_addr_bi = 32'h4000_0000; seed_bi = 32'h0F0F_0F0F; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        aborted = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (first_rd_ack >= 0) begin aborted = 1'b1; break; end
            tick();
        end
        check("rst_reached_read", 32'(aborted), 1);
        tick();
        rst_i = 1'b1;
        tick();
        check_all_zero("midrst");
        rst_i = 1'b0; resp_pend = 0;
        aborted = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done_o || busy_o) aborted = 1'b1;
        end
        check("midrst_no_done", 32'(aborted), 0);

        run("after_rst", 32'h4000_0000, 32'h0F0F_0F0F, 0, 1, 0, m, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
